// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker fetch unit.
// Holds the fetch FSM enum, the buffered entry layout and a PC helper.
package tinker_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] TINKER_RESET_PC = 64'h2000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] word;
  } fetch_ent_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/tinker_inst_fifo.sv
// Instruction buffer: DEPTH entries of {pc, word}, registered head.
// Ports: clk, reset, flush, push/wdata, pop, rdata (head), count.
module tinker_inst_fifo
  import tinker_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_ent_t                   wdata,
  input  logic                         pop,
  output fetch_ent_t                   rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_ent_t      r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= wdata;
        r_wp        <= bump(r_wp);
      end
      if (pop) begin
        r_rp <= bump(r_rp);
      end
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rdata = r_mem[r_rp];
  assign count = r_cnt;

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch: PC, in-order memory requests, buffered words.
// Ports: mem_req_*/mem_rsp_* to imem, inst_* to decode, redirect_* from EX.
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = TINKER_RESET_PC,
  parameter int              DEPTH    = 2
)(
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_word,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nx;
  logic [XLEN-1:0] r_rsp_pc;
  logic [XLEN-1:0] w_rsp_pc_nx;
  logic [XLEN-1:0] w_redir_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   w_outst_nx;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_drop_nx;
  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_inflight;
  logic            w_credit;
  logic            w_acc;
  logic            w_pop;
  logic            w_push;
  logic            w_drop_rsp;
  fetch_ent_t      w_ent;
  fetch_ent_t      w_head;

  assign w_redir_pc = align_pc(redirect_pc);

  // Buffer slots are reserved at request time, so in-flight plus
  // buffered never exceeds DEPTH and the FIFO cannot overflow.
  assign w_inflight = {1'b0, r_outst} + {1'b0, w_occ};
  assign w_credit   = w_inflight < (CW+1)'(DEPTH);

  assign mem_req_valid = !reset && (r_state == FETCH) && w_credit;
  assign mem_req_addr  = r_pc;

  assign w_acc      = mem_req_valid && mem_req_ready;
  assign w_pop      = inst_valid && inst_ready;
  assign w_drop_rsp = mem_rsp_valid && (r_drop != '0);
  assign w_push     = mem_rsp_valid && !w_drop_rsp && !redirect_valid;

  // r_rsp_pc is the PC of the oldest request whose word will be kept.
  assign w_ent = '{pc: r_rsp_pc, word: mem_rsp_data};

  always_comb begin
    w_outst_nx  = r_outst + CW'(w_acc) - CW'(mem_rsp_valid);
    w_pc_nx     = r_pc;
    w_rsp_pc_nx = r_rsp_pc;
    w_drop_nx   = r_drop;
    w_state_nx  = r_state;
    if (w_acc) begin
      w_pc_nx = r_pc + XLEN'(4);
    end
    if (w_push) begin
      w_rsp_pc_nx = r_rsp_pc + XLEN'(4);
    end
    if (w_drop_rsp) begin
      w_drop_nx = r_drop - CW'(1);
    end
    if (redirect_valid) begin
      // Everything still in flight after this cycle is old-path.
      w_pc_nx     = w_redir_pc;
      w_rsp_pc_nx = w_redir_pc;
      w_drop_nx   = w_outst_nx;
      w_state_nx  = (w_outst_nx != '0) ? FLUSH : FETCH;
    end else begin
      unique case (r_state)
        FLUSH:   if (w_drop_nx == '0) w_state_nx = FETCH;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_rsp_pc <= w_rsp_pc_nx;
      r_outst  <= w_outst_nx;
      r_drop   <= w_drop_nx;
    end
  end

  tinker_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (w_push),
    .wdata (w_ent),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_occ)
  );

  assign inst_valid = (w_occ != '0);
  assign inst_word  = w_head.word;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_tinker_fetch.sv
// Randomized scoreboard bench for tinker_fetch with an in-order memory.
// Expected words are queued on response and checked when decode pops.
module tb_tinker_fetch;

  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h2000;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  tinker_fetch #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } exp_t;

  req_t        pend[$];
  exp_t        expq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          epoch = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [63:0] exp_req_pc = RPC;
  logic        prev_redir = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr  = '0;

  function automatic logic [31:0] fw(input logic [63:0] a);
    return 32'hC000_0000 + a[33:2];
  endfunction

  function automatic void chk(input string nm,
                              input logic [127:0] act,
                              input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Monitor / reference model: memory in flight, stream epochs, kept words.
  always @(negedge clk) begin
    int   old;
    logic ev;
    req_t r;
    old = 0;
    if (reset) begin
      chk("rst_req_valid", 128'(mem_req_valid), 128'(1'b0));
      chk("rst_req_addr", 128'(mem_req_addr), 128'(RPC));
      chk("rst_inst_valid", 128'(inst_valid), 128'(1'b0));
      chk("rst_inst_word", 128'(inst_word), 128'(32'h0));
      chk("rst_inst_pc", 128'(inst_pc), 128'(64'h0));
      pend.delete();
      expq.delete();
      exp_req_pc = RPC;
      prev_redir = 1'b0;
      prev_stall = 1'b0;
    end else begin
      foreach (pend[i]) if (pend[i].ep != epoch) old++;
      ev = (old == 0) && (pend.size() + expq.size() < DEPTH);
      chk("req_valid", 128'(mem_req_valid), 128'(ev));
      if (mem_req_valid) begin
        chk("req_addr", 128'(mem_req_addr), 128'(exp_req_pc));
      end
      if (prev_stall) begin
        chk("req_hold", 128'({mem_req_valid, mem_req_addr}),
            128'({1'b1, prev_addr}));
      end
      if (prev_redir) begin
        chk("flush_empty", 128'(inst_valid), 128'(1'b0));
      end
      chk("inst_valid", 128'(inst_valid), 128'(expq.size() != 0));
      if (inst_valid && inst_ready && expq.size() != 0) begin
        chk("inst_pc_word", 128'({inst_pc, inst_word}),
            128'({expq[0].pc, expq[0].w}));
        void'(expq.pop_front());
      end
      if (mem_rsp_valid && pend.size() != 0) begin
        r = pend.pop_front();
        if (r.ep == epoch && !redirect_valid) begin
          expq.push_back('{pc: r.addr, w: fw(r.addr)});
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{addr: mem_req_addr, ep: epoch,
                         due: cyc + int'($urandom_range(lat_max, lat_min))});
        exp_req_pc = exp_req_pc + 64'd4;
      end
      prev_stall = mem_req_valid && !mem_req_ready && !redirect_valid;
      prev_addr  = mem_req_addr;
      if (redirect_valid) begin
        epoch++;
        expq.delete();
        exp_req_pc = {redirect_pc[63:2], 2'b00};
      end
      prev_redir = redirect_valid;
    end
    cyc++;
  end

  task automatic drive_rsp();
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = fw(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  task automatic step(input logic mr, input logic ir,
                      input logic rv, input logic [63:0] rp);
    @(posedge clk);
    #1;
    mem_req_ready  = mr;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rp;
    drive_rsp();
  endtask

  initial begin
    bit hit;
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Request channel stalled: address must hold at the reset PC.
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);

    // Streaming with 1-cycle memory.
    repeat (40) step(1'b1, 1'b1, 1'b0, '0);

    // Decode back-pressure, then drain.
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    repeat (12) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (pend.size() == 2) begin
        step(1'b1, 1'b1, 1'b1, 64'h3001);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b0, '0);
      end
    end
    chk("redir2_reached", 128'(hit), 128'(1'b1));
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect coinciding with a response and a pop.
    lat_min = 1;
    lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk);
      #1;
      mem_req_ready = 1'b1;
      inst_ready    = 1'b1;
      drive_rsp();
      hit = mem_rsp_valid && inst_valid;
      redirect_valid = hit;
      redirect_pc    = 64'h4000;
    end
    chk("redir_same_cycle_reached", 128'(hit), 128'(1'b1));
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);

    // Address wrap past the top of memory.
    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(3, 0) != 0),
           1'($urandom_range(9, 0) < 7),
           1'($urandom_range(99, 0) < 3),
           {$urandom, $urandom});
    end

    repeat (20) step(1'b1, 1'b1, 1'b0, '0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
